// File: rtl/alu_arbiter_if.sv
// rtl/alu_arbiter_if.sv - requester, shared-ALU and response signals of the ALU arbiter
interface alu_arbiter_if;
    // requester 0
    logic        req0_valid;
    logic        req0_ready;
    logic [3:0]  req0_cmd;
    logic [31:0] req0_first;
    logic [31:0] req0_second;
    logic        req0_set_flags;
    // requester 1
    logic        req1_valid;
    logic        req1_ready;
    logic [3:0]  req1_cmd;
    logic [31:0] req1_first;
    logic [31:0] req1_second;
    logic        req1_set_flags;
    // shared ALU
    logic [31:0] alu_first;
    logic [31:0] alu_second;
    logic [3:0]  alu_exe_cmd;
    logic [3:0]  alu_sr;
    logic [31:0] alu_result;
    logic [3:0]  alu_status;
    // response and held status
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_id;
    logic [31:0] rsp_result;
    logic [3:0]  rsp_status;
    logic        rsp_err;
    logic [3:0]  sr;

    modport slave (
        input  req0_valid, req0_cmd, req0_first, req0_second, req0_set_flags,
        input  req1_valid, req1_cmd, req1_first, req1_second, req1_set_flags,
        input  alu_result, alu_status, rsp_ready,
        output req0_ready, req1_ready,
        output alu_first, alu_second, alu_exe_cmd, alu_sr,
        output rsp_valid, rsp_id, rsp_result, rsp_status, rsp_err, sr
    );

    modport master (
        output req0_valid, req0_cmd, req0_first, req0_second, req0_set_flags,
        output req1_valid, req1_cmd, req1_first, req1_second, req1_set_flags,
        output alu_result, alu_status, rsp_ready,
        input  req0_ready, req1_ready,
        input  alu_first, alu_second, alu_exe_cmd, alu_sr,
        input  rsp_valid, rsp_id, rsp_result, rsp_status, rsp_err, sr
    );
endinterface

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin arbiter sharing one combinational ALU between two requesters
module alu_arbiter #(
    parameter logic [3:0] SR_RESET = 4'b0000
) (
    input  logic        clk,
    input  logic        rst,
    alu_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t      r_state;
    logic        r_ptr;
    logic [3:0]  r_cmd;
    logic [31:0] r_first;
    logic [31:0] r_second;
    logic        r_set_flags;
    logic        r_id;
    logic [3:0]  r_sr;
    logic        r_rsp_valid;
    logic        r_rsp_id;
    logic [31:0] r_rsp_result;
    logic [3:0]  r_rsp_status;
    logic        r_rsp_err;

    logic        w_any_valid;
    logic        w_grant_id;
    logic        w_grant;
    logic        w_exec;
    logic        w_legal;

    // the pointer only breaks ties; a lone requester always wins
    assign w_any_valid = bus.req0_valid | bus.req1_valid;
    assign w_grant_id  = (bus.req0_valid & bus.req1_valid) ? r_ptr : bus.req1_valid;
    assign w_grant     = (r_state == IDLE) & ~rst & w_any_valid;

    assign bus.req0_ready = w_grant & ~w_grant_id;
    assign bus.req1_ready = w_grant &  w_grant_id;

    // ALU operands are only live while executing so the ALU sees quiet inputs otherwise
    assign w_exec          = (r_state == EXEC);
    assign bus.alu_first   = w_exec ? r_first  : 32'd0;
    assign bus.alu_second  = w_exec ? r_second : 32'd0;
    assign bus.alu_exe_cmd = w_exec ? r_cmd    : 4'd0;
    assign bus.alu_sr      = r_sr;

    assign w_legal = (r_cmd >= 4'd1) && (r_cmd <= 4'd9);

    assign bus.rsp_valid  = r_rsp_valid;
    assign bus.rsp_id     = r_rsp_id;
    assign bus.rsp_result = r_rsp_result;
    assign bus.rsp_status = r_rsp_status;
    assign bus.rsp_err    = r_rsp_err;
    assign bus.sr         = r_sr;

    // grant / execute / respond sequencer with the held status register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_ptr        <= 1'b0;
            r_cmd        <= 4'd0;
            r_first      <= 32'd0;
            r_second     <= 32'd0;
            r_set_flags  <= 1'b0;
            r_id         <= 1'b0;
            r_sr         <= SR_RESET;
            r_rsp_valid  <= 1'b0;
            r_rsp_id     <= 1'b0;
            r_rsp_result <= 32'd0;
            r_rsp_status <= 4'd0;
            r_rsp_err    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any_valid) begin
                        r_cmd       <= w_grant_id ? bus.req1_cmd       : bus.req0_cmd;
                        r_first     <= w_grant_id ? bus.req1_first     : bus.req0_first;
                        r_second    <= w_grant_id ? bus.req1_second    : bus.req0_second;
                        r_set_flags <= w_grant_id ? bus.req1_set_flags : bus.req0_set_flags;
                        r_id        <= w_grant_id;
                        r_ptr       <= ~w_grant_id;
                        r_state     <= EXEC;
                    end
                end
                EXEC: begin
                    r_rsp_id    <= r_id;
                    r_rsp_valid <= 1'b1;
                    if (w_legal) begin
                        r_rsp_result <= bus.alu_result;
                        r_rsp_status <= bus.alu_status;
                        r_rsp_err    <= 1'b0;
                        if (r_set_flags) begin
                            r_sr <= bus.alu_status;
                        end
                    end else begin
                        r_rsp_result <= 32'd0;
                        r_rsp_status <= 4'd0;
                        r_rsp_err    <= 1'b1;
                    end
                    r_state <= RESP;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed self-checking bench for alu_arbiter
module tb_alu_arbiter;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    alu_arbiter_if bus();

    alu_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [32:0] m_wide;
    logic [31:0] m_res;
    logic        m_c;
    logic        m_v;

    // reference ALU: 1 mov, 2 add, 3 add-with-carry, 4 sub (carry = no borrow), others xor
    always_comb begin
        m_wide = 33'd0;
        m_res  = 32'd0;
        m_c    = 1'b0;
        m_v    = 1'b0;
        case (bus.alu_exe_cmd)
            4'd1: m_res = bus.alu_first;
            4'd2: begin
                m_wide = {1'b0, bus.alu_first} + {1'b0, bus.alu_second};
                m_res  = m_wide[31:0];
                m_c    = m_wide[32];
                m_v    = (bus.alu_first[31] == bus.alu_second[31]) && (m_res[31] != bus.alu_first[31]);
            end
            4'd3: begin
                m_wide = {1'b0, bus.alu_first} + {1'b0, bus.alu_second} + {32'd0, bus.alu_sr[2]};
                m_res  = m_wide[31:0];
                m_c    = m_wide[32];
                m_v    = (bus.alu_first[31] == bus.alu_second[31]) && (m_res[31] != bus.alu_first[31]);
            end
            4'd4: begin
                m_wide = {1'b0, bus.alu_first} + {1'b0, ~bus.alu_second} + 33'd1;
                m_res  = m_wide[31:0];
                m_c    = m_wide[32];
                m_v    = (bus.alu_first[31] != bus.alu_second[31]) && (m_res[31] != bus.alu_first[31]);
            end
            default: m_res = bus.alu_first ^ bus.alu_second;
        endcase
        bus.alu_result = m_res;
        bus.alu_status = {(m_res == 32'd0), m_c, m_res[31], m_v};
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic set_req0(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                            input logic sf, input logic v);
        bus.req0_cmd       = cmd;
        bus.req0_first     = a;
        bus.req0_second    = b;
        bus.req0_set_flags = sf;
        bus.req0_valid     = v;
    endtask

    task automatic set_req1(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                            input logic sf, input logic v);
        bus.req1_cmd       = cmd;
        bus.req1_first     = a;
        bus.req1_second    = b;
        bus.req1_set_flags = sf;
        bus.req1_valid     = v;
    endtask

    logic exp_g;

    initial begin
        rst = 1'b1;
        bus.rsp_ready = 1'b0;
        set_req0(4'd2, 32'd5, 32'd7, 1'b1, 1'b1);
        set_req1(4'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        cyc();
        cyc();

        // reset state, ready held low while rst is high
        chk("rst_ready0", 32'(bus.req0_ready), 32'd0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_sr", 32'(bus.sr), 32'd0);
        chk("rst_rsp_id", 32'(bus.rsp_id), 32'd0);
        chk("rst_rsp_result", bus.rsp_result, 32'd0);
        chk("rst_rsp_status", 32'(bus.rsp_status), 32'd0);
        chk("rst_rsp_err", 32'(bus.rsp_err), 32'd0);

        // single add 5 + 7
        rst = 1'b0;
        #1;
        chk("add_ready0", 32'(bus.req0_ready), 32'd1);
        chk("add_ready1", 32'(bus.req1_ready), 32'd0);
        chk("idle_alu_first", bus.alu_first, 32'd0);
        cyc();
        bus.req0_valid = 1'b0;
        #1;
        chk("exec_ready0", 32'(bus.req0_ready), 32'd0);
        chk("exec_alu_first", bus.alu_first, 32'd5);
        chk("exec_alu_second", bus.alu_second, 32'd7);
        chk("exec_alu_cmd", 32'(bus.alu_exe_cmd), 32'd2);
        chk("exec_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        cyc();
        chk("add_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        chk("add_rsp_id", 32'(bus.rsp_id), 32'd0);
        chk("add_rsp_result", bus.rsp_result, 32'd12);
        chk("add_rsp_status", 32'(bus.rsp_status), 32'd0);
        chk("add_rsp_err", 32'(bus.rsp_err), 32'd0);
        chk("add_sr", 32'(bus.sr), 32'd0);
        chk("resp_alu_cmd", 32'(bus.alu_exe_cmd), 32'd0);
        bus.rsp_ready = 1'b1;
        cyc();
        chk("add_done_rsp_valid", 32'(bus.rsp_valid), 32'd0);

        // contention from reset: grants alternate 0,1,0,1
        rst = 1'b1;
        set_req0(4'd1, 32'h100, 32'd0, 1'b0, 1'b1);
        set_req1(4'd1, 32'h200, 32'd0, 1'b0, 1'b1);
        cyc();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            exp_g = i[0];
            #1;
            chk("cont_ready0", 32'(bus.req0_ready), 32'(!exp_g));
            chk("cont_ready1", 32'(bus.req1_ready), 32'(exp_g));
            cyc();
            cyc();
            chk("cont_rsp_id", 32'(bus.rsp_id), 32'(exp_g));
            chk("cont_rsp_result", bus.rsp_result, exp_g ? 32'h200 : 32'h100);
            chk("cont_handshake_ready0", 32'(bus.req0_ready), 32'd0);
            chk("cont_handshake_ready1", 32'(bus.req1_ready), 32'd0);
            cyc();
        end

        // flags: 3 - 3 sets z and c, then add-with-carry consumes c
        bus.req0_valid = 1'b0;
        set_req1(4'd4, 32'd3, 32'd3, 1'b1, 1'b1);
        #1;
        chk("sub_ready1", 32'(bus.req1_ready), 32'd1);
        cyc();
        bus.req1_valid = 1'b0;
        #1;
        chk("sub_alu_sr", 32'(bus.alu_sr), 32'd0);
        cyc();
        chk("sub_rsp_result", bus.rsp_result, 32'd0);
        chk("sub_rsp_status", 32'(bus.rsp_status), 32'hC);
        chk("sub_rsp_id", 32'(bus.rsp_id), 32'd1);
        chk("sub_sr", 32'(bus.sr), 32'hC);
        cyc();
        set_req1(4'd3, 32'd1, 32'd1, 1'b0, 1'b1);
        #1;
        chk("adc_ready1", 32'(bus.req1_ready), 32'd1);
        cyc();
        bus.req1_valid = 1'b0;
        #1;
        chk("adc_alu_sr", 32'(bus.alu_sr), 32'hC);
        cyc();
        chk("adc_rsp_result", bus.rsp_result, 32'd3);
        chk("adc_sr_kept", 32'(bus.sr), 32'hC);
        cyc();

        // illegal commands 1111 and 1010 with set_flags
        set_req0(4'hF, 32'd9, 32'd9, 1'b1, 1'b1);
        cyc();
        bus.req0_valid = 1'b0;
        cyc();
        chk("ill_rsp_err", 32'(bus.rsp_err), 32'd1);
        chk("ill_rsp_result", bus.rsp_result, 32'd0);
        chk("ill_rsp_status", 32'(bus.rsp_status), 32'd0);
        chk("ill_sr", 32'(bus.sr), 32'hC);
        cyc();
        set_req0(4'hA, 32'd6, 32'd3, 1'b1, 1'b1);
        cyc();
        bus.req0_valid = 1'b0;
        cyc();
        chk("ill_a_rsp_err", 32'(bus.rsp_err), 32'd1);
        chk("ill_a_sr", 32'(bus.sr), 32'hC);
        cyc();

        // backpressure on highest legal command 1001
        bus.rsp_ready = 1'b0;
        set_req0(4'd9, 32'hF0, 32'h0F, 1'b0, 1'b1);
        cyc();
        bus.req0_valid = 1'b0;
        set_req1(4'd4, 32'd1, 32'd2, 1'b1, 1'b1);
        cyc();
        for (int k = 0; k < 5; k++) begin
            chk("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
            chk("bp_rsp_result", bus.rsp_result, 32'hFF);
            chk("bp_rsp_err", 32'(bus.rsp_err), 32'd0);
            chk("bp_rsp_id", 32'(bus.rsp_id), 32'd0);
            chk("bp_ready0", 32'(bus.req0_ready), 32'd0);
            chk("bp_ready1", 32'(bus.req1_ready), 32'd0);
            cyc();
        end
        bus.rsp_ready = 1'b1;
        #1;
        chk("bp_handshake_ready1", 32'(bus.req1_ready), 32'd0);
        cyc();
        chk("bp_idle_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("bp_next_ready1", 32'(bus.req1_ready), 32'd1);
        cyc();
        bus.req1_valid = 1'b0;
        #1;
        chk("mid_exec_alu_first", bus.alu_first, 32'd1);

        // reset while executing: no response, sr and pointer back to reset values
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        #1;
        chk("mid_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("mid_rst_sr", 32'(bus.sr), 32'd0);
        chk("mid_rst_rsp_result", bus.rsp_result, 32'd0);
        chk("mid_rst_ready0", 32'(bus.req0_ready), 32'd0);
        chk("mid_rst_ready1", 32'(bus.req1_ready), 32'd0);
        cyc();
        chk("mid_rst_no_rsp", 32'(bus.rsp_valid), 32'd0);
        chk("mid_rst_sr_hold", 32'(bus.sr), 32'd0);
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        #1;
        chk("mid_rst_ptr_ready0", 32'(bus.req0_ready), 32'd1);
        chk("mid_rst_ptr_ready1", 32'(bus.req1_ready), 32'd0);
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
